// File: rtl/cep_link_arb_pkg.sv
// cep_link_arb_pkg
//   Types and constants shared by the CEP link arbiter and its bench.
//   DATA_W / IS_REQ_BIT mirror cep_defines.vh; last_e is the round-robin
//   pointer (which class was granted most recently).
`include "cep_defines.vh"

package cep_link_arb_pkg;

  localparam int DATA_W       = `CEP_DATA_WIDTH;
  localparam int IS_REQ_BIT   = `CEP_IS_REQ;
  localparam int CREDITS_DFLT = `CEP_ARB_CREDITS;

  typedef enum logic {
    LAST_REQ  = `CEP_ARB_LAST_REQ,
    LAST_RESP = `CEP_ARB_LAST_RESP
  } last_e;

  // True when the packet's class bit disagrees with the port it arrived on.
  function automatic logic class_mismatch(input logic [DATA_W-1:0] pkg,
                                          input logic              is_req_port);
    return pkg[IS_REQ_BIT] != is_req_port;
  endfunction

endpackage

// File: rtl/cep_credit_counter.sv
// cep_credit_counter
//   Per-class credit counter. Starts (and resets) full at CREDITS,
//   decrements on a grant, increments on a returned credit. A return while
//   already full saturates and raises overflow for that cycle.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   inc         - credit returned by the far side
//   dec         - packet granted (caller guarantees cnt > 0)
//   cnt         - current credit count
//   overflow    - combinational: return with counter full and no grant
module cep_credit_counter #(
  parameter int CREDITS = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(CREDITS);

  assign overflow = inc && !dec && (cnt == MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= MAX;
    end else if (inc && !dec && (cnt != MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cep_defines.vh
// Shared CEP definitions: packet width, class bit position, arbiter
// credit default and round-robin pointer encoding.
`ifndef CEP_DEFINES_VH
`define CEP_DEFINES_VH

`define CEP_DATA_WIDTH    32
`define CEP_IS_REQ        31
`define CEP_ARB_CREDITS   8
`define CEP_ARB_LAST_REQ  1'b0
`define CEP_ARB_LAST_RESP 1'b1

`endif

// File: rtl/cep_link_arb.sv
// cep_link_arb
//   Credit-based two-class (request/response) arbiter feeding one link
//   output register. One-cycle latency from acceptance to out_valid and
//   bubble-free at full rate: the register reloads in the same cycle it
//   drains. A class is eligible when valid with credits > 0.
// Build option:
//   CEP_ARB_RESP_PRIO_EN - responses always win over requests; otherwise
//                          round-robin between the two classes.
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   req_valid/req_pkg/req_ready   - request-class input handshake
//   resp_valid/resp_pkg/resp_ready- response-class input handshake
//   out_valid/out_pkg/out_ready   - link output handshake
//   req_credit_ret/resp_credit_ret- one credit returned per high cycle
//   credit_err                    - sticky: credit overflow or class mismatch
//
// Round-robin pointer:
//   state     | meaning
//   LAST_REQ  | request class granted last; response wins the next tie
//   LAST_RESP | response class granted last (reset); request wins next tie
`include "cep_defines.vh"

module cep_link_arb
  import cep_link_arb_pkg::*;
#(
  parameter int CREDITS = `CEP_ARB_CREDITS,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_pkg,
  output logic              req_ready,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_pkg,
  output logic              resp_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pkg,
  input  logic              out_ready,
  input  logic              req_credit_ret,
  input  logic              resp_credit_ret,
  output logic              credit_err
);

  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] resp_cnt;
  logic             req_ovf;
  logic             resp_ovf;
  logic             req_elig;
  logic             resp_elig;
  logic             load_ok;
  logic             grant_req;
  logic             grant_resp;
  logic             mismatch;

  assign req_elig  = req_valid  && (req_cnt  != '0);
  assign resp_elig = resp_valid && (resp_cnt != '0);

  // Gating with rst_n keeps both readies low throughout reset.
  assign load_ok = rst_n && (!out_valid || out_ready);

`ifdef CEP_ARB_RESP_PRIO_EN
  assign grant_resp = load_ok && resp_elig;
  assign grant_req  = load_ok && req_elig && !resp_elig;
`else
  last_e last_q;

  assign grant_req  = load_ok && req_elig && (!resp_elig || (last_q == LAST_RESP));
  assign grant_resp = load_ok && resp_elig && !grant_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= LAST_RESP;
    end else if (grant_req) begin
      last_q <= LAST_REQ;
    end else if (grant_resp) begin
      last_q <= LAST_RESP;
    end
  end
`endif

  assign req_ready  = grant_req;
  assign resp_ready = grant_resp;

  // Mismatched packets are still forwarded; only the error flag records it.
  assign mismatch = (grant_req  && class_mismatch(req_pkg,  1'b1)) ||
                    (grant_resp && class_mismatch(resp_pkg, 1'b0));

  cep_credit_counter #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_req_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (req_credit_ret),
    .dec      (grant_req),
    .cnt      (req_cnt),
    .overflow (req_ovf)
  );

  cep_credit_counter #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_resp_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (resp_credit_ret),
    .dec      (grant_resp),
    .cnt      (resp_cnt),
    .overflow (resp_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pkg    <= '0;
      credit_err <= 1'b0;
    end else begin
      if (grant_req) begin
        out_valid <= 1'b1;
        out_pkg   <= req_pkg;
      end else if (grant_resp) begin
        out_valid <= 1'b1;
        out_pkg   <= resp_pkg;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      credit_err <= credit_err || req_ovf || resp_ovf || mismatch;
    end
  end

endmodule

// File: doc/cep_link_arb.md
CEP_LINK_ARB -- requirements
Module: cep_link_arb

Interface
REQ-001 SHALL have parameter CREDITS, default 8: initial and maximum credit count per traffic class (1..15).
REQ-002 SHALL have parameter CNT_W, default 4: credit counter width, which must hold CREDITS.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1: request-class packet offered.
REQ-006 SHALL have port req_pkg, input, `CEP_DATA_WIDTH: request-class CEP packet.
REQ-007 SHALL have port req_ready, output, 1: request packet accepted this cycle when high with req_valid.
REQ-008 SHALL have port resp_valid, input, 1: response-class packet offered.
REQ-009 SHALL have port resp_pkg, input, `CEP_DATA_WIDTH: response-class CEP packet.
REQ-010 SHALL have port resp_ready, output, 1: response packet accepted.
REQ-011 SHALL have port out_valid, output, 1: link packet valid.
REQ-012 SHALL have port out_pkg, output, `CEP_DATA_WIDTH: link packet.
REQ-013 SHALL have port out_ready, input, 1: link consumer accepts.
REQ-014 SHALL have port req_credit_ret, input, 1: one request credit returned by the far side per high cycle.
REQ-015 SHALL have port resp_credit_ret, input, 1: one response credit returned per high cycle.
REQ-016 SHALL have port credit_err, output, 1: sticky; set on credit overflow or class mismatch.

Function
REQ-017 SHALL hold one output register (out_valid/out_pkg); a new packet SHALL be loaded only when the register is empty or drained in the same cycle (out_valid && out_ready).
REQ-018 SHALL have a latency of exactly one cycle from acceptance (valid && ready) to out_valid high; bubble-free at full rate.
REQ-019 SHALL keep out_pkg stable while out_valid && !out_ready.
REQ-020 SHALL deem a class eligible when its valid is high and its credit count is > 0.
REQ-021 SHALL use a two-state round-robin pointer LAST_REQ/LAST_RESP: when both classes are eligible, grant the class not last granted, then update the pointer to the granted class; with a single eligible class, grant it.
REQ-022 SHALL assert at most one of req_ready/resp_ready per cycle; ready SHALL be 0 for a class with zero credits.
REQ-023 SHALL decrement a class counter by 1 on grant and increment it by 1 on credit_ret; when both occur in the same cycle, the counter SHALL be unchanged.
REQ-024 SHALL, on credit_ret with the counter already at CREDITS and no same-cycle grant, saturate the counter and set credit_err.
REQ-025 SHALL set credit_err when a granted packet's `CEP_IS_REQ bit disagrees with its port class (request port carrying 0, or response port carrying 1); the packet SHALL still be forwarded.

Reset
REQ-026 SHALL, on clk edge with rst_n=0: out_valid=0, out_pkg=0, both counters=CREDITS, pointer=LAST_RESP (requests win the first tie), credit_err=0.
REQ-027 SHALL drop any packet held in the output register on reset mid-transfer; ready outputs SHALL be 0 while rst_n=0.

Configuration
REQ-028 SHALL, when CEP_ARB_RESP_PRIO_EN is defined, grant an eligible response ahead of any request, leaving the pointer unused; when it is undefined, arbitrate per REQ-021.

Structure
REQ-029 SHALL take CEP_DATA_WIDTH and CEP_IS_REQ from the shared cep_defines.vh; CREDITS default and the pointer encoding SHALL be added there as CEP_ARB_CREDITS and CEP_ARB_LAST_* macros.
REQ-030 SHALL instantiate sub-module cep_credit_counter (inc, dec, saturate, overflow flag) once per class.

Verification
REQ-031 SHALL test: both valid every cycle, out_ready=1, credit_ret every cycle -> output alternates req, resp, req, resp starting with req; no bubbles.
REQ-032 SHALL test: req_valid only, no credit return, CREDITS=8 -> exactly 8 packets pass, then req_ready stays 0; one req_credit_ret pulse -> exactly one more packet.
REQ-033 SHALL test: out_ready=0 for 5 cycles with a packet held -> out_pkg unchanged, both readies 0; out_ready=1 -> next packet appears on the following cycle.
REQ-034 SHALL test: grant and credit_ret in the same cycle at count 3 -> count stays 3; credit_ret at count 8 -> count 8, credit_err=1.
REQ-035 SHALL test: with CEP_ARB_RESP_PRIO_EN defined and both classes valid for 4 cycles -> 4 responses, 0 requests forwarded.
REQ-036 SHALL test: rst_n low for one cycle while out_valid=1 -> next cycle out_valid=0, counters=8, credit_err=0.
